// File: rtl/ir_packet_decoder.sv
// IR packet decoder: synchronizes the demodulated IR envelope, measures
// burst/gap lengths in carrier-pulse units and decodes one packet
// (start, car-select, right/left/backward/forward) into a 4-bit direction word.
module ir_packet_decoder #(
    parameter int Pulse_Counter_Width = 8,
    parameter int StartBurstSize      = 192,
    parameter int CarSelectBurstSize  = 24,
    parameter int GapBurstSize        = 24,
    parameter int AssertBurstSize     = 48,
    parameter int DeAssertBurstSize   = 24,
    parameter int Tolerance           = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ir_in,
    input  logic       Pulse_Strobe,
    output logic [3:0] dir_state,
    output logic       packet_valid,
    output logic       packet_error,
    output logic       busy
);

    localparam int CW = Pulse_Counter_Width;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_MAX  = '1;
    localparam cnt_t START_LO = cnt_t'(StartBurstSize - Tolerance);
    localparam cnt_t START_HI = cnt_t'(StartBurstSize + Tolerance);
    localparam cnt_t CS_LO    = cnt_t'(CarSelectBurstSize - Tolerance);
    localparam cnt_t CS_HI    = cnt_t'(CarSelectBurstSize + Tolerance);
    localparam cnt_t GAP_LO   = cnt_t'(GapBurstSize - Tolerance);
    localparam cnt_t GAP_HI   = cnt_t'(GapBurstSize + Tolerance);
    localparam cnt_t AS_LO    = cnt_t'(AssertBurstSize - Tolerance);
    localparam cnt_t AS_HI    = cnt_t'(AssertBurstSize + Tolerance);
    localparam cnt_t DAS_LO   = cnt_t'(DeAssertBurstSize - Tolerance);
    localparam cnt_t DAS_HI   = cnt_t'(DeAssertBurstSize + Tolerance);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_CARSEL,
        S_DATA,
        S_FINAL_GAP
    } state_t;

    // A saturated count never matches a window, even if a window reaches the max
    function automatic logic in_win(input cnt_t len, input cnt_t lo, input cnt_t hi);
        return (len != CNT_MAX) && (len >= lo) && (len <= hi);
    endfunction

    logic       meta_q, meta_d;
    logic       ir_s_q, ir_s_d;
    logic       ir_dly_q, ir_dly_d;
    cnt_t       cnt_q, cnt_d;
    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       exp_carsel_q, exp_carsel_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] dir_q, dir_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       busy_q, busy_d;

    logic       edge_det, rise_det, fall_det;
    logic       err, bit_ok;

    // Synchronizer, edge detection and saturating segment-length counter
    always_comb begin
        meta_d   = ir_in;
        ir_s_d   = meta_q;
        ir_dly_d = ir_s_q;
        edge_det = ir_s_q ^ ir_dly_q;
        rise_det = edge_det & ir_s_q;
        fall_det = edge_det & ~ir_s_q;
        if (edge_det) begin
            cnt_d = Pulse_Strobe ? cnt_t'(1) : '0;
        end else if (Pulse_Strobe && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Packet FSM next-state: lengths are judged on the count before the edge reload
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        exp_carsel_d = exp_carsel_q;
        shadow_d     = shadow_q;
        dir_d        = dir_q;
        valid_d      = 1'b0;
        error_d      = 1'b0;
        busy_d       = busy_q;
        err          = 1'b0;
        bit_ok       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise_det) state_d = S_START;
            end
            S_START: begin
                if (fall_det) begin
                    if (in_win(cnt_q, START_LO, START_HI)) begin
                        state_d      = S_GAP;
                        busy_d       = 1'b1;
                        idx_d        = '0;
                        exp_carsel_d = 1'b1;
                        shadow_d     = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (rise_det) begin
                    if (in_win(cnt_q, GAP_LO, GAP_HI))
                        state_d = exp_carsel_q ? S_CARSEL : S_DATA;
                    else
                        err = 1'b1;
                end else if (cnt_d > GAP_HI) begin
                    err = 1'b1;
                end
            end
            S_CARSEL: begin
                if (fall_det) begin
                    if (in_win(cnt_q, CS_LO, CS_HI)) begin
                        state_d      = S_GAP;
                        exp_carsel_d = 1'b0;
                        idx_d        = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (fall_det) begin
                    if (in_win(cnt_q, AS_LO, AS_HI)) begin
                        shadow_d[idx_q] = 1'b1;
                        bit_ok          = 1'b1;
                    end else if (in_win(cnt_q, DAS_LO, DAS_HI)) begin
                        shadow_d[idx_q] = 1'b0;
                        bit_ok          = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                    if (bit_ok) begin
                        if (idx_q == 2'd3) begin
                            state_d = S_FINAL_GAP;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_FINAL_GAP: begin
                if (rise_det) begin
                    err = 1'b1;
                end else if (cnt_d >= GAP_LO) begin
                    dir_d    = shadow_q;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    shadow_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err) begin
            error_d  = 1'b1;
            busy_d   = 1'b0;
            shadow_d = '0;
            state_d  = S_IDLE;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_q       <= 1'b0;
            ir_s_q       <= 1'b0;
            ir_dly_q     <= 1'b0;
            cnt_q        <= '0;
            state_q      <= S_IDLE;
            idx_q        <= '0;
            exp_carsel_q <= 1'b0;
            shadow_q     <= '0;
            dir_q        <= '0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            meta_q       <= meta_d;
            ir_s_q       <= ir_s_d;
            ir_dly_q     <= ir_dly_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            exp_carsel_q <= exp_carsel_d;
            shadow_q     <= shadow_d;
            dir_q        <= dir_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
        end
    end

    assign dir_state    = dir_q;
    assign packet_valid = valid_q;
    assign packet_error = error_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ir_packet_decoder.sv
// Directed bench for ir_packet_decoder: packets are built from segments of
// N carrier pulses (4 CLK per pulse, strobe on the last CLK of each pulse).
module tb_ir_packet_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ir_in = 1'b0;
    logic       Pulse_Strobe = 1'b0;
    logic [3:0] dir_state;
    logic       packet_valid;
    logic       packet_error;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    int valid_cnt = 0;
    int err_cnt   = 0;
    int busy_cyc  = 0;
    int both_cnt  = 0;
    logic [3:0] valid_dir = '0;

    ir_packet_decoder #(
        .Pulse_Counter_Width(8),
        .StartBurstSize(192),
        .CarSelectBurstSize(24),
        .GapBurstSize(24),
        .AssertBurstSize(48),
        .DeAssertBurstSize(24),
        .Tolerance(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ir_in(ir_in),
        .Pulse_Strobe(Pulse_Strobe),
        .dir_state(dir_state),
        .packet_valid(packet_valid),
        .packet_error(packet_error),
        .busy(busy)
    );

    initial forever #5 CLK = ~CLK;

    // Event monitor sampling 1ns after each rising edge
    always @(posedge CLK) begin
        #1;
        if (packet_valid) begin
            valid_cnt++;
            valid_dir = dir_state;
        end
        if (packet_error) err_cnt++;
        if (packet_valid && packet_error) both_cnt++;
        if (busy) busy_cyc++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic seg(input logic lvl, input int n);
        ir_in = lvl;
        for (int i = 0; i < n; i++) begin
            Pulse_Strobe = 1'b0;
            repeat (3) @(negedge CLK);
            Pulse_Strobe = 1'b1;
            @(negedge CLK);
        end
        Pulse_Strobe = 1'b0;
    endtask

    task automatic send_packet(input int st, input int cs, input int g,
                               input int r, input int l, input int b, input int f);
        seg(1'b1, st); seg(1'b0, g);
        seg(1'b1, cs); seg(1'b0, g);
        seg(1'b1, r);  seg(1'b0, g);
        seg(1'b1, l);  seg(1'b0, g);
        seg(1'b1, b);  seg(1'b0, g);
        seg(1'b1, f);  seg(1'b0, 24);
    endtask

    int v0, e0, b0;

    initial begin
        // Reset state
        repeat (4) @(negedge CLK);
        check("rst_dir", dir_state, 0);
        check("rst_valid", packet_valid, 0);
        check("rst_error", packet_error, 0);
        check("rst_busy", busy, 0);
        RST = 1'b0;
        seg(1'b0, 5);

        // Nominal packet
        v0 = valid_cnt; e0 = err_cnt; b0 = busy_cyc;
        send_packet(192, 24, 24, 48, 24, 24, 48);
        check("t1_valid_count", valid_cnt - v0, 1);
        check("t1_dir", dir_state, 4'b1001);
        check("t1_valid_dir", valid_dir, 4'b1001);
        check("t1_no_error", err_cnt - e0, 0);
        check("t1_busy_seen", int'(busy_cyc > b0), 1);
        check("t1_busy_end", busy, 0);

        // Back-to-back all-deassert then all-assert
        v0 = valid_cnt; e0 = err_cnt;
        send_packet(192, 24, 24, 24, 24, 24, 24);
        check("t2a_valid_count", valid_cnt - v0, 1);
        check("t2a_dir", dir_state, 4'b0000);
        send_packet(192, 24, 24, 48, 48, 48, 48);
        check("t2b_valid_count", valid_cnt - v0, 2);
        check("t2b_dir", dir_state, 4'b1111);
        check("t2_no_error", err_cnt - e0, 0);

        // Right burst of 36 pulses is out of both data windows
        v0 = valid_cnt; e0 = err_cnt;
        seg(1'b1, 192); seg(1'b0, 24); seg(1'b1, 24); seg(1'b0, 24);
        seg(1'b1, 36); seg(1'b0, 1);
        check("t4_error", err_cnt - e0, 1);
        check("t4_dir_hold", dir_state, 4'b1111);
        check("t4_busy", busy, 0);
        seg(1'b0, 30);
        check("t4_no_valid", valid_cnt - v0, 0);
        check("t4_single_error", err_cnt - e0, 1);

        // Gap after car-select stretched past 28 pulses
        v0 = valid_cnt; e0 = err_cnt;
        seg(1'b1, 192); seg(1'b0, 24); seg(1'b1, 24);
        seg(1'b0, 28);
        check("t5_no_error_at28", err_cnt - e0, 0);
        check("t5_busy_at28", busy, 1);
        seg(1'b0, 1);
        check("t5_error_at29", err_cnt - e0, 1);
        check("t5_busy_cleared", busy, 0);
        seg(1'b0, 10);
        check("t5_no_valid", valid_cnt - v0, 0);

        // Tolerance edges
        v0 = valid_cnt; e0 = err_cnt;
        send_packet(188, 24, 20, 44, 24, 52, 24);
        check("t3a_valid_count", valid_cnt - v0, 1);
        check("t3a_dir", dir_state, 4'b0101);
        send_packet(196, 28, 28, 52, 44, 28, 20);
        check("t3b_valid_count", valid_cnt - v0, 2);
        check("t3b_dir", dir_state, 4'b0011);
        check("t3_no_error", err_cnt - e0, 0);
        b0 = busy_cyc; e0 = err_cnt; v0 = valid_cnt;
        seg(1'b1, 187); seg(1'b0, 30);
        check("t3c_no_busy", busy_cyc - b0, 0);
        check("t3c_no_error", err_cnt - e0, 0);
        check("t3c_no_valid", valid_cnt - v0, 0);
        check("t3c_dir_hold", dir_state, 4'b0011);

        // Reset in the middle of the left burst, then a clean packet
        seg(1'b1, 192); seg(1'b0, 24); seg(1'b1, 24); seg(1'b0, 24);
        seg(1'b1, 48); seg(1'b0, 24);
        seg(1'b1, 10);
        check("t6_busy_before_rst", busy, 1);
        RST = 1'b1;
        ir_in = 1'b0;
        #1;
        check("t6_rst_dir", dir_state, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", packet_valid, 0);
        check("t6_rst_error", packet_error, 0);
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        seg(1'b0, 5);
        v0 = valid_cnt; e0 = err_cnt;
        send_packet(192, 24, 24, 48, 24, 24, 48);
        check("t6_valid_count", valid_cnt - v0, 1);
        check("t6_dir", dir_state, 4'b1001);
        check("t6_no_error", err_cnt - e0, 0);

        check("never_valid_and_error", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
